gpr_file_bypass: RTL
====================

# gpr_file_bypass

Parametrised MIPS general-purpose register file with per-byte write enables, rising-edge commit, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It sits between decode (Rs/Rt read, busy check for interlock) and writeback (byte-masked Rd write). It replaces the fixed 32x32 negedge file so the pipeline can run single-edge with long-latency loads tracked in hardware.

## Interface
Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8 (NB = DATA_W/8 byte lanes)
- NREG, 32, number of registers; power of two, at least 2
- ADDR_W, log2(NREG), address width (derived; not overridden)

Ports:
- Clk  in  1  single clock; all state updates on the rising edge
- Rst_n  in  1  asynchronous active-low reset
- Rs_addr  in  ADDR_W  read port A address
- Rt_addr  in  ADDR_W  read port B address
- Rs_out  out  DATA_W  read port A data (bypassed)
- Rt_out  out  DATA_W  read port B data (bypassed)
- Rs_busy  out  1  register at Rs_addr has a pending write
- Rt_busy  out  1  register at Rt_addr has a pending write
- Rd_addr  in  ADDR_W  write address
- Rd_write_byte_en  in  NB  per-byte write enable; bit i covers Rd_in[8i+7:8i]
- Rd_in  in  DATA_W  write data
- Rd_clr_busy  in  1  this write retires the pending write on Rd_addr
- Busy_set_en  in  1  mark Busy_set_addr as pending (load issued)
- Busy_set_addr  in  ADDR_W  register to mark pending
- Busy_count  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: NREG x DATA_W array plus NREG-bit busy vector plus Busy_count register.
- Register 0: reads return 0, never busy; writes, clears and sets to address 0 are ignored.
- Write: at rising edge, for every i with Rd_write_byte_en[i]=1 and Rd_addr!=0, byte i of register Rd_addr takes byte i of Rd_in; other bytes hold. All 2^NB enable patterns legal, including non-contiguous ones; all-zero is a no-op.
- Read (combinational): per byte i, if Rs_addr==Rd_addr, Rs_addr!=0, Rd_write_byte_en[i]=1 then Rs_out byte i = Rd_in byte i, else stored byte. Identical rule for Rt. Both ports may address the same register.
- Scoreboard next state per register r!=0: busy'[r] = (busy[r] & ~clr[r]) | set[r], where clr[r] = Rd_clr_busy & (Rd_addr==r) and set[r] = Busy_set_en & (Busy_set_addr==r). Simultaneous set and clear of the same register: set wins (back-to-back loads to same target).
- Rd_clr_busy is honoured regardless of Rd_write_byte_en (retire with no data allowed).
- Clearing a non-busy register or setting an already-busy register is legal and changes nothing.
- Rs_busy = busy[Rs_addr] & ~clr[Rs_addr]; Rt_busy likewise (clear is bypassed; same-cycle set is not visible until next cycle). Address 0 always reports 0.
- Busy_count' = popcount(busy'); updated incrementally (net -1, 0 or +1 per cycle), never exceeds NREG-1.

## Timing
- Reset (Rst_n=0, asynchronous, any time including mid-write): all registers 0, busy vector 0, Busy_count 0; Rs_out/Rt_out read 0 from storage (bypass still applies combinationally to nonzero addresses while Rst_n=0, but nothing is committed); Rs_busy/Rt_busy 0.
- Release of Rst_n is synchronised by the caller; first commit is the first rising edge with Rst_n=1.
- Write latency: 0 cycles visible on read ports via bypass; stored at the edge.
- Busy set latency: 1 cycle (visible after the edge). Busy clear latency: 0 cycles on Rs_busy/Rt_busy, 1 cycle on Busy_count.
- No handshake stalls: every input is consumed every cycle; the block never back-pressures.

## Test plan
- Reset: drive Rst_n=0 mid-cycle after writing R5=0x55556789 -> Rs_out(R5)=0, Busy_count=0 immediately; after release R5 reads 0.
- Byte-masked write: R9=0x54678932, write Rd_in=0xAABBCCDD en=4'b1010 -> next cycle R9=0xAA67CC32; same cycle Rs_out(R9)=0xAA67CC32 via bypass.
- R0 immunity: write 0xFFFFFFFF en=4'b1111 to R0, Busy_set_en on R0 -> Rs_out=0, Rs_busy=0, Busy_count unchanged.
- Scoreboard: set R3, then R4 on successive cycles -> Busy_count 1 then 2, Rs_busy(R3)=1; write R3 with Rd_clr_busy=1 -> Rs_busy(R3)=0 same cycle, Busy_count=1 next cycle.
- Simultaneous set+clear on R7 (busy) -> R7 stays busy, Busy_count unchanged; set R8 + clear R7 same cycle -> count unchanged, R7 free, R8 busy.
- Parameter sweep DATA_W=64, NREG=16: en=8'h81 write 0x1122334455667788 to R15 from 0 -> R15=0x1100000000000088; fill all 15 busy bits -> Busy_count=15.

Source files
------------

// File: rtl/gpr_file_bypass.sv
// Register file with byte-masked writes, same-cycle write-to-read bypass and pending-write scoreboard.
// Reads are combinational (0 cycles); writes/busy sets commit on the rising edge; never back-pressures.
module gpr_file_bypass #(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 32,
  localparam int ADDR_W = $clog2(NREG),
  localparam int NB     = DATA_W / 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Rs_addr,
  input  logic [ADDR_W-1:0] Rt_addr,
  output logic [DATA_W-1:0] Rs_out,
  output logic [DATA_W-1:0] Rt_out,
  output logic              Rs_busy,
  output logic              Rt_busy,
  input  logic [ADDR_W-1:0] Rd_addr,
  input  logic [NB-1:0]     Rd_write_byte_en,
  input  logic [DATA_W-1:0] Rd_in,
  input  logic              Rd_clr_busy,
  input  logic              Busy_set_en,
  input  logic [ADDR_W-1:0] Busy_set_addr,
  output logic [ADDR_W:0]   Busy_count
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              set_new;
  logic              clr_real;

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (Rd_addr != '0) begin
      for (int i = 0; i < NB; i++)
        if (Rd_write_byte_en[i]) regs[Rd_addr][8*i +: 8] <= Rd_in[8*i +: 8];
    end
  end

  function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] d;
    d = '0;
    if (addr != '0) begin
      d = regs[addr];
      for (int i = 0; i < NB; i++)
        if (addr == Rd_addr && Rd_write_byte_en[i]) d[8*i +: 8] = Rd_in[8*i +: 8];
    end
    return d;
  endfunction

  always_comb begin
    Rs_out = bypass_read(Rs_addr);
    Rt_out = bypass_read(Rt_addr);
  end

  // Clear is bypassed onto the busy outputs; a same-cycle set only shows after the edge.
  assign Rs_busy = (Rs_addr != '0) && busy[Rs_addr] && !(Rd_clr_busy && Rd_addr == Rs_addr);
  assign Rt_busy = (Rt_addr != '0) && busy[Rt_addr] && !(Rd_clr_busy && Rd_addr == Rt_addr);

  always_comb begin
    busy_nxt = busy;
    if (Rd_clr_busy) busy_nxt[Rd_addr]       = 1'b0;
    if (Busy_set_en) busy_nxt[Busy_set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Count deltas only track real 0->1 and 1->0 transitions; set beats clear on the same register.
  assign set_new  = Busy_set_en && (Busy_set_addr != '0) && !busy[Busy_set_addr];
  assign clr_real = Rd_clr_busy && (Rd_addr != '0) && busy[Rd_addr]
                    && !(Busy_set_en && Busy_set_addr == Rd_addr);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy       <= '0;
      Busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      Busy_count <= Busy_count + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_real};
    end
  end

endmodule
